mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequential arbiter that shares one single-port, variable-latency external memory between the instruction-fetch (IF) and data (MEM) stages of the MIPS pipeline. It accepts one outstanding access at a time, gives the data access priority over the fetch, and returns per-requester stall signals that feed the pipeline freeze logic alongside the hazard unit. A watchdog terminates accesses the memory never acknowledges and flags a bus error.

## Interface
- TIMEOUT, 16: maximum cycles ext_req may stay high without ext_ack before forced completion (2..255).
- Clk  in  1  clock, all state changes on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  32  fetch word address.
- if_rdata  out  32  fetched instruction, valid in if_ready cycle.
- if_ready  out  1  one-cycle completion pulse for fetch.
- mem_req  in  1  data request, held until mem_ready.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data, valid in mem_ready cycle.
- mem_ready  out  1  one-cycle completion pulse for data.
- IFstall  out  1  if_req & ~if_ready (combinational).
- MEMstall  out  1  mem_req & ~mem_ready (combinational).
- ext_req, ext_we  out  1  registered memory request / write enable.
- ext_addr, ext_wdata  out  32  registered address / write data.
- ext_rdata  in  32  memory read data, sampled with ext_ack.
- ext_ack  in  1  memory completion, earliest one cycle after ext_req rises.
- bus_err  out  1  one-cycle pulse on timeout completion.

## Operation
- States: IDLE (2'b00), DATA (2'b01), INST (2'b10); 2'b11 unreachable, returns to IDLE with outputs 0.
- IDLE: at edge, mem_req=1 -> DATA, latch mem_addr/mem_we/mem_wdata onto ext_*, ext_req=1. Else if_req=1 -> INST, latch if_addr, ext_we=0, ext_req=1. Else stay, ext_req=0.
- Simultaneous mem_req and if_req in IDLE: DATA wins; fetch remains stalled and is granted at the edge ending the mem_ready cycle.
- DATA/INST: ext_* held constant. On edge with ext_ack=1: capture ext_rdata into requester rdata (stores capture it too, ignored), pulse that requester's ready next cycle, ext_req=0, go IDLE.
- Watchdog: 8-bit counter cleared on entry to DATA/INST, increments each busy cycle without ext_ack. When it reaches TIMEOUT-1 without ack: complete as above with rdata=32'h0, bus_err=1 for the ready cycle, ext_req=0. ext_ack in the same cycle wins; no error.
- Ready cycle is spent in IDLE; a request high at the edge closing that cycle is a new access (pipeline has advanced).
- rdata outputs hold last captured value until next completion for that requester.
- ext_ack while in IDLE ignored.

## Timing
- Reset (async, immediate): state IDLE, counter 0, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, if_rdata=0, mem_rdata=0, if_ready=0, mem_ready=0, bus_err=0. Stalls follow requests (IFstall=if_req).
- Reset mid-access: access abandoned, ext_req drops asynchronously, no ready pulse.
- Latency: request sampled at edge 0 -> ext_req high cycle 1 -> ext_ack in cycle k (k>=1) -> ready in cycle k+1. Minimum 2 cycles request-to-ready; back-to-back accesses every 2 cycles.
- Timeout: ready/bus_err in cycle TIMEOUT+1 after grant edge.
- Fetch behind data with zero-wait memory: mem_ready cycle 2, if_ready cycle 4.

## Test plan
- Single load, ext_ack in cycle 1 returning 32'hDEADBEEF -> mem_ready pulses cycle 2, mem_rdata=32'hDEADBEEF, MEMstall high cycles 0-1 only.
- Both requests at edge 0, zero-wait memory -> ext_addr shows mem_addr first then if_addr; mem_ready cycle 2, if_ready cycle 4, IFstall high until cycle 4.
- Store mem_addr=32'h100, mem_wdata=32'h12345678, ack after 3 wait cycles -> ext_we=1, ext_wdata stable throughout, mem_ready one cycle after ack.
- TIMEOUT=4, ext_ack never asserted -> ready and bus_err together one cycle after 4th busy cycle, rdata=0, ext_req low; ack arriving exactly at TIMEOUT-1 -> no bus_err, real data returned.
- Rst low while INST busy -> ext_req low immediately, no if_ready; after release with if_req still high, fetch re-granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side request/response signals and external memory bus
// signals shared between the arbiter (slave) and its environment (master).
interface mem_port_arbiter_if;
  // Handshake: a requester raises *_req with stable address/data and holds it
  // until the matching *_ready pulse; the memory answers ext_req with a single
  // ext_ack cycle, and ext_* stay constant while ext_req is high.
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        IFstall;
  logic        MEMstall;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_ack;
  logic        bus_err;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           ext_rdata, ext_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready, IFstall, MEMstall,
           ext_req, ext_we, ext_addr, ext_wdata, bus_err
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           ext_rdata, ext_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready, IFstall, MEMstall,
           ext_req, ext_we, ext_addr, ext_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between MIPS fetch and data
// stages: one access in flight, data beats fetch, watchdog ends hung accesses.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DATA  = 2'b01,
    S_INST  = 2'b10,
    S_UNUSED = 2'b11
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wd_cnt;
  logic        busy;
  logic        timeout;
  logic        done;
  logic        grant_mem;
  logic        grant_if;

  logic        ext_we_q;
  logic [31:0] ext_addr_q;
  logic [31:0] ext_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        if_ready_q;
  logic        mem_ready_q;
  logic        bus_err_q;

  assign busy      = (state == S_DATA) || (state == S_INST);
  // A real acknowledge in the last allowed cycle beats the watchdog.
  assign timeout   = busy && !bus.ext_ack && (wd_cnt == WD_LAST);
  assign done      = busy && (bus.ext_ack || timeout);
  assign grant_mem = (state == S_IDLE) && bus.mem_req;
  assign grant_if  = (state == S_IDLE) && !bus.mem_req && bus.if_req;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_mem) begin
          state_nxt = S_DATA;
        end else if (grant_if) begin
          state_nxt = S_INST;
        end
      end
      S_DATA, S_INST: begin
        if (done) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Access registers, watchdog and completion pulses.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wd_cnt      <= 8'd0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= 32'h0;
      ext_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_mem) begin
            ext_we_q    <= bus.mem_we;
            ext_addr_q  <= bus.mem_addr;
            ext_wdata_q <= bus.mem_wdata;
            wd_cnt      <= 8'd0;
          end else if (grant_if) begin
            ext_we_q   <= 1'b0;
            ext_addr_q <= bus.if_addr;
            wd_cnt     <= 8'd0;
          end
        end
        S_DATA, S_INST: begin
          if (done) begin
            if (state == S_DATA) begin
              mem_rdata_q <= timeout ? 32'h0 : bus.ext_rdata;
              mem_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= timeout ? 32'h0 : bus.ext_rdata;
              if_ready_q <= 1'b1;
            end
            bus_err_q <= timeout;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: begin
          wd_cnt      <= 8'd0;
          ext_we_q    <= 1'b0;
          ext_addr_q  <= 32'h0;
          ext_wdata_q <= 32'h0;
        end
      endcase
    end
  end

  // ext_req comes straight from the state register so reset drops it at once.
  always_comb begin
    bus.ext_req   = busy;
    bus.ext_we    = ext_we_q;
    bus.ext_addr  = ext_addr_q;
    bus.ext_wdata = ext_wdata_q;
    bus.if_rdata  = if_rdata_q;
    bus.mem_rdata = mem_rdata_q;
    bus.if_ready  = if_ready_q;
    bus.mem_ready = mem_ready_q;
    bus.bus_err   = bus_err_q;
    bus.IFstall   = bus.if_req & ~if_ready_q;
    bus.MEMstall  = bus.mem_req & ~mem_ready_q;
    dbg_state     = state;
  end

endmodule
